// File: rtl/vt52_key_encoder.sv
// Purpose: turn keyboard events and identify requests into the VT52 byte stream sent to the host (ESC sequences for cursor/PF keys, ESC / K reply).
// Latency: first byte valid the cycle after a key is accepted, two cycles after an ident_req pulse; one byte per cycle when out_ready is high.
// Backpressure: out_ready low holds out_data/out_valid stable; key_ready stays low while a sequence is in flight or an identify reply is pending.
// Optional feature: define VT52_KEYPAD_ALT_EN to add keypad alternate mode (keypad_alt_set/keypad_alt_clr, ESC ? x sequences).

module vt52_key_encoder #(
  parameter logic [7:0] ESC_CODE   = 8'h1B,
  parameter logic [7:0] IDENT_CHAR = 8'h4B
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] key_code,
  input  logic       key_special,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       ident_req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
`ifdef VT52_KEYPAD_ALT_EN
  ,
  input  logic       keypad_alt_set,
  input  logic       keypad_alt_clr
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] seq_q [4];
  logic [7:0] seq_d [4];
  logic [1:0] len_q, len_d;
  logic [1:0] idx_q, idx_d;
  logic       ident_pending_q, ident_pending_d;
  logic       alt_mode;

  // Sequence produced by the key currently offered; map_len==0 means "drop it".
  logic [1:0] map_len;
  logic [7:0] map_b0, map_b1, map_b2;

`ifdef VT52_KEYPAD_ALT_EN
  // Keypad alternate mode flag; a set pulse beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alt_mode <= 1'b0;
    end else if (keypad_alt_set) begin
      alt_mode <= 1'b1;
    end else if (keypad_alt_clr) begin
      alt_mode <= 1'b0;
    end
  end
`else
  assign alt_mode = 1'b0;
`endif

  // Translate the offered key into up to three output bytes.
  always_comb begin
    map_len = 2'd0;
    map_b0  = 8'h00;
    map_b1  = 8'h00;
    map_b2  = 8'h00;
    if (!key_special) begin
      map_len = 2'd1;
      map_b0  = key_code;
    end else if (key_code >= 8'h01 && key_code <= 8'h04) begin
      // Cursor keys: 01..04 -> ESC A..D
      map_len = 2'd2;
      map_b0  = ESC_CODE;
      map_b1  = key_code + 8'h40;
    end else if (key_code >= 8'h05 && key_code <= 8'h07) begin
      // PF1..PF3: 05..07 -> ESC P..R
      map_len = 2'd2;
      map_b0  = ESC_CODE;
      map_b1  = key_code + 8'h4B;
    end else if (key_code >= 8'h10 && key_code <= 8'h19) begin
      if (alt_mode) begin
        // Alternate keypad digits: ESC ? p..y
        map_len = 2'd3;
        map_b0  = ESC_CODE;
        map_b1  = 8'h3F;
        map_b2  = key_code + 8'h60;
      end else begin
        // Numeric keypad digits: '0'..'9'
        map_len = 2'd1;
        map_b0  = key_code + 8'h20;
      end
    end else if (key_code == 8'h1A) begin
      if (alt_mode) begin
        map_len = 2'd3;
        map_b0  = ESC_CODE;
        map_b1  = 8'h3F;
        map_b2  = 8'h4D;
      end else begin
        map_len = 2'd1;
        map_b0  = 8'h0D;
      end
    end
  end

  // Keys are only taken in IDLE with no identify reply waiting; held low in reset.
  assign key_ready = reset_n && (state_q == S_IDLE) && !ident_pending_q;

  // Output byte is the buffered entry selected by idx while emitting.
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = out_valid ? seq_q[idx_q] : 8'h00;

  // Next-state logic: load a sequence in IDLE, step through it in EMIT.
  always_comb begin
    state_d         = state_q;
    seq_d           = seq_q;
    len_d           = len_q;
    idx_d           = idx_q;
    ident_pending_d = ident_pending_q | ident_req;

    case (state_q)
      S_IDLE: begin
        idx_d = 2'd0;
        if (ident_pending_q) begin
          // Identify reply has priority over new keys; a request in this
          // very cycle is kept so it is not lost.
          seq_d[0]        = ESC_CODE;
          seq_d[1]        = 8'h2F;
          seq_d[2]        = IDENT_CHAR;
          seq_d[3]        = 8'h00;
          len_d           = 2'd3;
          ident_pending_d = ident_req;
          state_d         = S_EMIT;
        end else if (key_valid && map_len != 2'd0) begin
          seq_d[0] = map_b0;
          seq_d[1] = map_b1;
          seq_d[2] = map_b2;
          seq_d[3] = 8'h00;
          len_d    = map_len;
          state_d  = S_EMIT;
        end
        // An unmapped special key is accepted via key_ready and simply dropped.
      end
      S_EMIT: begin
        if (out_ready) begin
          if (idx_q == len_q - 2'd1) begin
            idx_d   = 2'd0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset discards any partially sent sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      seq_q[0]        <= 8'h00;
      seq_q[1]        <= 8'h00;
      seq_q[2]        <= 8'h00;
      seq_q[3]        <= 8'h00;
      len_q           <= 2'd0;
      idx_q           <= 2'd0;
      ident_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      seq_q           <= seq_d;
      len_q           <= len_d;
      idx_q           <= idx_d;
      ident_pending_q <= ident_pending_d;
    end
  end

endmodule

// File: tb/tb_vt52_key_encoder.sv
// Bench for vt52_key_encoder: directed cycle-accurate steps followed by randomized keys
// with random output backpressure, checked against a table-driven byte-stream model.
// VT52_KEYPAD_ALT_EN enables the keypad alternate-mode steps.
`timescale 1ns/1ps
module tb_vt52_key_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] key_code;
  logic       key_special;
  logic       key_valid;
  logic       key_ready;
  logic       ident_req;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef VT52_KEYPAD_ALT_EN
  logic       keypad_alt_set;
  logic       keypad_alt_clr;
`endif

  vt52_key_encoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_code    (key_code),
    .key_special (key_special),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .ident_req   (ident_req),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef VT52_KEYPAD_ALT_EN
    ,
    .keypad_alt_set (keypad_alt_set),
    .keypad_alt_clr (keypad_alt_clr)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit         rand_rdy = 1'b0;
  bit         alt_model = 1'b0;

  // Record every byte the host would actually consume.
  always @(posedge clk) begin
    if (reset_n && out_valid && out_ready) got.push_back(out_data);
  end

  // Random backpressure during the randomized phase.
  always @(negedge clk) begin
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: the VT52 byte stream a key should produce, by lookup tables.
  task automatic model_key(input logic [7:0] c, input bit sp);
    string arrows = "ABCD";
    string pfs    = "PQR";
    string digits = "0123456789";
    string altk   = "pqrstuvwxy";
    int    n;
    n = int'(c);
    if (!sp) begin
      exp_q.push_back(c);
    end else if (n >= 1 && n <= 4) begin
      exp_q.push_back(8'h1B);
      exp_q.push_back(arrows[n-1]);
    end else if (n >= 5 && n <= 7) begin
      exp_q.push_back(8'h1B);
      exp_q.push_back(pfs[n-5]);
    end else if (n >= 16 && n <= 25) begin
      if (alt_model) begin
        exp_q.push_back(8'h1B);
        exp_q.push_back("?");
        exp_q.push_back(altk[n-16]);
      end else begin
        exp_q.push_back(digits[n-16]);
      end
    end else if (n == 26) begin
      if (alt_model) begin
        exp_q.push_back(8'h1B);
        exp_q.push_back("?");
        exp_q.push_back("M");
      end else begin
        exp_q.push_back(8'h0D);
      end
    end
  endtask

  task automatic model_ident();
    exp_q.push_back(8'h1B);
    exp_q.push_back("/");
    exp_q.push_back("K");
  endtask

  // Offer a key and wait (bounded) for it to be taken; returns at the
  // falling edge just after the accepting edge.
  task automatic send_key(input logic [7:0] c, input bit sp);
    bit done = 1'b0;
    @(negedge clk);
    key_code    = c;
    key_special = sp;
    key_valid   = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      if (key_ready) done = 1'b1;
    end
    @(negedge clk);
    key_valid = 1'b0;
    chk("key_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic expect_got(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic clear_logs();
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    reset_n     = 1'b0;
    key_code    = 8'h00;
    key_special = 1'b0;
    key_valid   = 1'b0;
    ident_req   = 1'b0;
    out_ready   = 1'b0;
`ifdef VT52_KEYPAD_ALT_EN
    keypad_alt_set = 1'b0;
    keypad_alt_clr = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_key_ready", {31'd0, key_ready}, 32'd0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_key_ready", {31'd0, key_ready}, 32'd1);

    // Plain key 'a'
    clear_logs();
    model_key(8'h61, 1'b0);
    send_key(8'h61, 1'b0);
    chk("a_valid", {31'd0, out_valid}, 32'd1);
    chk("a_data", {24'd0, out_data}, 32'h61);
    chk("a_key_ready_busy", {31'd0, key_ready}, 32'd0);
    @(negedge clk);
    chk("a_valid_after", {31'd0, out_valid}, 32'd0);
    chk("a_key_ready_after", {31'd0, key_ready}, 32'd1);
    expect_got("a_stream");

    // Cursor up, no backpressure
    clear_logs();
    model_key(8'h01, 1'b1);
    send_key(8'h01, 1'b1);
    chk("up_b0", {24'd0, out_data}, 32'h1B);
    @(negedge clk);
    chk("up_b1", {24'd0, out_data}, 32'h41);
    chk("up_b1_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    chk("up_done_valid", {31'd0, out_valid}, 32'd0);
    expect_got("up_stream");

    // Cursor up with 3 stall cycles on each byte
    clear_logs();
    model_key(8'h01, 1'b1);
    out_ready = 1'b0;
    send_key(8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_b0_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_b0_data", {24'd0, out_data}, 32'h1B);
      if (i < 2) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_b1_data", {24'd0, out_data}, 32'h41);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_done_valid", {31'd0, out_valid}, 32'd0);
    expect_got("stall_stream");

    // Single identify request
    clear_logs();
    model_ident();
    ident_req = 1'b1;
    @(negedge clk);
    ident_req = 1'b0;
    chk("id_wait_valid", {31'd0, out_valid}, 32'd0);
    chk("id_wait_key_ready", {31'd0, key_ready}, 32'd0);
    @(negedge clk);
    chk("id_b0", {24'd0, out_data}, 32'h1B);
    @(negedge clk);
    chk("id_b1", {24'd0, out_data}, 32'h2F);
    @(negedge clk);
    chk("id_b2", {24'd0, out_data}, 32'h4B);
    @(negedge clk);
    chk("id_done_valid", {31'd0, out_valid}, 32'd0);
    chk("id_done_key_ready", {31'd0, key_ready}, 32'd1);
    expect_got("id_stream");

    // Two requests two cycles apart while busy coalesce into one reply
    clear_logs();
    model_key(8'h71, 1'b0);
    model_ident();
    out_ready = 1'b0;
    send_key(8'h71, 1'b0);
    ident_req = 1'b1;
    @(negedge clk);
    ident_req = 1'b0;
    @(negedge clk);
    ident_req = 1'b1;
    @(negedge clk);
    ident_req = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    expect_got("coalesce_stream");

    // Key and identify in the same cycle; another key waits for the reply
    clear_logs();
    model_key(8'h78, 1'b0);
    model_ident();
    model_key(8'h79, 1'b0);
    key_code    = 8'h78;
    key_special = 1'b0;
    key_valid   = 1'b1;
    ident_req   = 1'b1;
    @(negedge clk);
    ident_req = 1'b0;
    key_code  = 8'h79;
    chk("sim_x_data", {24'd0, out_data}, 32'h78);
    chk("sim_x_key_ready", {31'd0, key_ready}, 32'd0);
    @(negedge clk);
    chk("sim_gap_valid", {31'd0, out_valid}, 32'd0);
    chk("sim_gap_key_ready", {31'd0, key_ready}, 32'd0);
    @(negedge clk);
    chk("sim_id_b0", {24'd0, out_data}, 32'h1B);
    chk("sim_id_key_ready", {31'd0, key_ready}, 32'd0);
    @(negedge clk);
    chk("sim_id_b1", {24'd0, out_data}, 32'h2F);
    @(negedge clk);
    chk("sim_id_b2", {24'd0, out_data}, 32'h4B);
    @(negedge clk);
    chk("sim_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("sim_idle_key_ready", {31'd0, key_ready}, 32'd1);
    @(negedge clk);
    key_valid = 1'b0;
    chk("sim_y_data", {24'd0, out_data}, 32'h79);
    @(negedge clk);
    expect_got("sim_stream");

    // Unmapped special code is swallowed
    clear_logs();
    send_key(8'h7F, 1'b1);
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("drop_key_ready", {31'd0, key_ready}, 32'd1);
    @(negedge clk);
    chk("drop_valid2", {31'd0, out_valid}, 32'd0);
    expect_got("drop_stream");

    // Reset in the middle of ESC C discards the tail
    clear_logs();
    exp_q.push_back(8'h1B);
    send_key(8'h03, 1'b1);
    chk("rc_b0", {24'd0, out_data}, 32'h1B);
    @(negedge clk);
    chk("rc_b1_offered", {24'd0, out_data}, 32'h43);
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rc_reset_valid", {31'd0, out_valid}, 32'd0);
    chk("rc_reset_key_ready", {31'd0, key_ready}, 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rc_after_valid", {31'd0, out_valid}, 32'd0);
    expect_got("rc_stream");

`ifdef VT52_KEYPAD_ALT_EN
    // Keypad alternate mode on, then off
    clear_logs();
    keypad_alt_set = 1'b1;
    @(negedge clk);
    keypad_alt_set = 1'b0;
    alt_model = 1'b1;
    model_key(8'h13, 1'b1);
    send_key(8'h13, 1'b1);
    repeat (5) @(negedge clk);
    keypad_alt_clr = 1'b1;
    @(negedge clk);
    keypad_alt_clr = 1'b0;
    alt_model = 1'b0;
    model_key(8'h13, 1'b1);
    send_key(8'h13, 1'b1);
    repeat (3) @(negedge clk);
    expect_got("alt_stream");
`endif

    // Randomized keys with random backpressure
    clear_logs();
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [7:0] c;
      bit         sp;
      sp = bit'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       c = 8'($urandom_range(1, 7));
        1:       c = 8'($urandom_range(8'h10, 8'h1A));
        2:       c = 8'($urandom_range(0, 255));
        default: c = 8'($urandom_range(0, 8'h1F));
      endcase
      model_key(c, sp);
      send_key(c, sp);
    end
    for (int i = 0; i < 2000 && got.size() < exp_q.size(); i++) @(negedge clk);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    expect_got("rand_stream");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vt52_key_encoder.md
Name: vt52_key_encoder

Overview:
Converts keyboard key events into the VT52 byte stream sent to the host over the USB UART input pipeline (terminal -> host). Normal keys become one byte. Cursor and PF keys become two-byte ESC sequences. An identify request from the command handler (host sent ESC Z) is answered with ESC / K. Sits between the PS/2 keyboard decoder and usb_uart's uart_in_* port, and is the transmit-side counterpart of the command handler's escape-sequence parser.

Parameters:
ESC_CODE, 8'h1B, escape byte that prefixes every multi-byte sequence
IDENT_CHAR, 8'h4B, final byte of the identify reply ('K' = VT52 without copier)

Ports:
clk  input  1  system clock (48 MHz fast_clk domain)
reset_n  input  1  asynchronous, active-low reset
key_code  input  8  ASCII byte, or special-key code when key_special=1
key_special  input  1  qualifies key_code as a special-key code
key_valid  input  1  key event offered
key_ready  output  1  key event accepted when key_valid && key_ready
ident_req  input  1  single-cycle pulse from command handler on ESC Z
out_data  output  8  byte toward usb_uart uart_in_data
out_valid  output  1  byte offered
out_ready  input  1  byte consumed when out_valid && out_ready

Behaviour:
- Reset (async, reset_n=0): state=IDLE, out_valid=0, out_data=0, key_ready=0 while reset is asserted, ident_pending=0, sequence buffer cleared. A reset mid-sequence discards the remaining bytes.
- ident_pending: set on any cycle with ident_req=1; cleared when the identify sequence is loaded. Multiple requests before service coalesce into one reply.
- key_ready = (state==IDLE) && !ident_pending (registered-state combinational).
- FSM IDLE:
  - If ident_pending: load buffer {ESC_CODE, 8'h2F, IDENT_CHAR}, len=3, clear pending, go to EMIT.
  - Else if key_valid: accept the key, load its sequence, go to EMIT. If the code maps to nothing, stay in IDLE.
- FSM EMIT: out_valid=1, out_data=buf[idx]. On handshake: if idx==len-1 go to IDLE, else idx+1. out_data and out_valid hold stable while out_ready=0.
- Key mapping:
  - key_special=0: the byte itself, len=1.
  - Special codes: 8'h01 up -> ESC A; 8'h02 down -> ESC B; 8'h03 right -> ESC C; 8'h04 left -> ESC D; 8'h05/06/07 (PF1/PF2/PF3) -> ESC P / ESC Q / ESC R.
  - Keypad codes 8'h10..8'h19 -> '0'..'9'; 8'h1A (keypad enter) -> 8'h0D. All of these are len=1 (see Optional Feature).
  - Any other special code is accepted and dropped with no output.
- Latency:
  - Key accepted at edge N -> first byte has out_valid=1 after edge N.
  - ident_req at edge N while IDLE -> first byte valid after edge N+1.
  - With out_ready held at 1, a len-L sequence occupies exactly L consecutive cycles, followed by one IDLE cycle.
- Simultaneous ident_req and key_valid in IDLE: the key is accepted (pending not yet set), and the identify reply follows immediately after the key's sequence.
- ident_req arriving during EMIT is latched, and no keys are accepted until the reply has been sent.
- The output never interleaves bytes of two sequences.

Optional Feature:
VT52_KEYPAD_ALT_EN
- Adds inputs keypad_alt_set and keypad_alt_clr (1-bit pulses from the command handler on ESC = / ESC >) and a mode flag alt_mode (reset 0).
- Set wins if both pulses occur in the same cycle.
- With alt_mode=1: keypad codes 8'h10..8'h19 -> ESC ? p..y (3 bytes: ESC_CODE, 8'h3F, 8'h70+n), and 8'h1A -> ESC ? M.
- Without the macro, or with alt_mode=0: keypad codes map to ASCII digits and CR, as specified above.

Test Plan:
- Reset, then key 'a' (8'h61, special=0) with out_ready=1 -> one cycle out_data=8'h61, out_valid=1; key_ready low that cycle, high the next.
- Special 8'h01 with out_ready=1 -> 8'h1B then 8'h41 on consecutive cycles. Repeat with out_ready low for 3 cycles on each byte -> data held stable, same two bytes, no duplication.
- ident_req pulse in IDLE -> 8'h1B, 8'h2F, 8'h4B. Two ident_req pulses 2 cycles apart -> exactly one reply.
- ident_req and key_valid ('x') in the same cycle -> 8'h78, then 8'h1B, 8'h2F, 8'h4B. Key_valid offered during the reply is not accepted until the reply ends.
- Special 8'h7F -> accepted, no out_valid. reset_n pulsed low after the first byte of ESC C -> out_valid drops immediately and 8'h43 is never sent.
- (VT52_KEYPAD_ALT_EN) keypad_alt_set, then code 8'h13 -> 8'h1B, 8'h3F, 8'h73. After keypad_alt_clr, code 8'h13 -> 8'h33.
